// File: rtl/contador_pkg.sv
// Shared types and constants for the ascending/descending BCD counter.
// Digit type, BCD limits and active-low gfedcba seven-segment patterns.
package contador_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic bcd_t bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single-decade BCD up/down cell with clamped load.
// carry_borrow flags that an enabled step rolls this digit over.
module bcd_digit
    import contador_pkg::*;
#(
    parameter logic [3:0] RESET_VALUE = 4'd0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       carry_borrow
);

    bcd_t q_next;
    logic at_edge;

    assign at_edge      = dir ? (q == BCD_MAX) : (q == BCD_MIN);
    assign carry_borrow = en & ~load & at_edge;

    always_comb begin
        q_next = q;
        unique case (1'b1)
            load:                q_next = bcd_clamp(d);
            (en && dir):         q_next = at_edge ? BCD_MIN : q + 4'd1;
            (en && !dir):        q_next = at_edge ? BCD_MAX : q - 4'd1;
            default:             q_next = q;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/updown_bcd_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a synchronised slow clock.
// Define SEVEN_SEG_EN to add registered active-low seven-segment outputs.
module updown_bcd_counter
    import contador_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       enable,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] count,
    output logic       wrap,
    output logic       step
`ifdef SEVEN_SEG_EN
    ,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_units
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;
    logic                   accept;
    logic                   units_cb;
    logic                   tens_cb;
    logic [3:0]             units_q;
    logic [3:0]             tens_q;

    // slow_clk is only ever sampled as data
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick   = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign accept = tick & enable & ~load;

    bcd_digit #(
        .RESET_VALUE(RESET_VALUE[3:0])
    ) u_units (
        .clock_in     (clock_in),
        .reset        (reset),
        .en           (accept),
        .dir          (dir),
        .load         (load),
        .d            (load_value[3:0]),
        .q            (units_q),
        .carry_borrow (units_cb)
    );

    bcd_digit #(
        .RESET_VALUE(RESET_VALUE[7:4])
    ) u_tens (
        .clock_in     (clock_in),
        .reset        (reset),
        .en           (units_cb),
        .dir          (dir),
        .load         (load),
        .d            (load_value[7:4]),
        .q            (tens_q),
        .carry_borrow (tens_cb)
    );

    assign count = {tens_q, units_q};

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wrap <= 1'b0;
            step <= 1'b0;
        end else begin
            wrap <= tens_cb;
            step <= accept;
        end
    end

`ifdef SEVEN_SEG_EN
    always_ff @(posedge clock_in) begin
        if (reset) begin
            seg_tens  <= seg_decode(RESET_VALUE[7:4]);
            seg_units <= seg_decode(RESET_VALUE[3:0]);
        end else begin
            seg_tens  <= seg_decode(tens_q);
            seg_units <= seg_decode(units_q);
        end
    end
`endif

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Directed bench for updown_bcd_counter with hand-computed expectations.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_updown_bcd_counter;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       slow_clk = 1'b0;
    logic       enable = 1'b1;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] count;
    logic       wrap;
    logic       step;
`ifdef SEVEN_SEG_EN
    logic [6:0] seg_tens;
    logic [6:0] seg_units;
`endif

    int checks = 0;
    int failures = 0;
    int step_seen = 0;
    int wrap_seen = 0;

    updown_bcd_counter #(
        .SYNC_STAGES (2),
        .RESET_VALUE (8'h00)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .enable     (enable),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .wrap       (wrap),
        .step       (step)
`ifdef SEVEN_SEG_EN
        ,
        .seg_tens   (seg_tens),
        .seg_units  (seg_units)
`endif
    );

    always #5 clock_in = ~clock_in;

    always @(negedge clock_in) begin
        if (step) step_seen++;
        if (wrap) wrap_seen++;
    end

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load = 1'b1;
        wait_neg(1);
        load = 1'b0;
    endtask

    task automatic pulse();
        slow_clk = 1'b1;
        wait_neg(2);
        slow_clk = 1'b0;
        wait_neg(4);
    endtask

    task automatic clear_seen();
        step_seen = 0;
        wrap_seen = 0;
    endtask

    initial begin
        wait_neg(1);
        check("reset_count", count, 8'h00);
        check("reset_step", {7'd0, step}, 8'd0);
        check("reset_wrap", {7'd0, wrap}, 8'd0);
        reset = 1'b0;
        wait_neg(1);
        clear_seen();

        // ten up steps from zero
        for (int i = 0; i < 10; i++) pulse();
        check("up10_count", count, 8'h10);
        check("up10_steps", 8'(step_seen), 8'd10);
        check("up10_wraps", 8'(wrap_seen), 8'd0);

        // 98 -> 99 -> 00 with cycle-exact latency on the wrapping edge
        do_load(8'h98);
        check("load_98", count, 8'h98);
        clear_seen();
        pulse();
        check("up_99", count, 8'h99);
        slow_clk = 1'b1;
        wait_neg(2);
        check("lat_hold", count, 8'h99);
        check("lat_nostep", {7'd0, step}, 8'd0);
        wait_neg(1);
        check("wrap_count", count, 8'h00);
        check("wrap_pulse", {7'd0, wrap}, 8'd1);
        check("wrap_step", {7'd0, step}, 8'd1);
        wait_neg(1);
        check("wrap_drop", {7'd0, wrap}, 8'd0);
        check("step_drop", {7'd0, step}, 8'd0);
        slow_clk = 1'b0;
        wait_neg(4);
        check("wrap_once", 8'(wrap_seen), 8'd1);

        // down through 00 and a tens borrow
        dir = 1'b0;
        do_load(8'h00);
        clear_seen();
        pulse();
        check("down_99", count, 8'h99);
        check("down_wrap", 8'(wrap_seen), 8'd1);
        pulse();
        check("down_98", count, 8'h98);
        do_load(8'h40);
        pulse();
        check("down_39", count, 8'h39);

        // clamped loads
        do_load(8'h3C);
        check("clamp_3C", count, 8'h39);
        do_load(8'hAF);
        check("clamp_AF", count, 8'h99);

        // load wins over a coincident tick
        dir = 1'b1;
        do_load(8'h20);
        clear_seen();
        slow_clk = 1'b1;
        wait_neg(2);
        load_value = 8'h57;
        load = 1'b1;
        wait_neg(1);
        load = 1'b0;
        check("ldtick_count", count, 8'h57);
        check("ldtick_step", {7'd0, step}, 8'd0);
        slow_clk = 1'b0;
        wait_neg(4);
        check("ldtick_after", count, 8'h57);
        check("ldtick_nostep", 8'(step_seen), 8'd0);

        // disabled steps are discarded
        enable = 1'b0;
        clear_seen();
        for (int i = 0; i < 5; i++) begin
            dir = ~dir;
            pulse();
        end
        check("dis_count", count, 8'h57);
        check("dis_steps", 8'(step_seen), 8'd0);
        enable = 1'b1;
        dir = 1'b1;

        // reset one cycle after a rise drops the in-flight tick
        do_load(8'h25);
        clear_seen();
        slow_clk = 1'b1;
        wait_neg(1);
        slow_clk = 1'b0;
        reset = 1'b1;
        wait_neg(1);
        check("rst_mid_count", count, 8'h00);
        reset = 1'b0;
        wait_neg(6);
        check("rst_mid_hold", count, 8'h00);
        check("rst_mid_nostep", 8'(step_seen), 8'd0);

`ifdef SEVEN_SEG_EN
        do_load(8'h42);
        wait_neg(1);
        check("seg_tens", {1'b0, seg_tens}, 8'b0011001);
        check("seg_units", {1'b0, seg_units}, 8'b0100100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
